// File: rtl/jpeg_byte_stuffer.sv
// JPEG entropy-stream byte stuffer: serialises packed code words MSB byte first,
// inserts 0x00 after every 0xFF data byte and optionally appends the EOI marker.
module jpeg_byte_stuffer #(
    parameter int WORD_W   = 32,
    parameter bit EMIT_EOI = 1'b1,
    localparam int NB = WORD_W / 8,
    localparam int BW = $clog2(NB + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [BW-1:0]     in_bytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [15:0]       stuff_count
);

    // One spare bit so idx+2 never wraps when NB+1 is a power of two
    localparam int IW = BW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_STUFF  = 3'd2;
    localparam logic [2:0] S_EOI_FF = 3'd3;
    localparam logic [2:0] S_EOI_D9 = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              eop_q, eop_d;
    logic [IW-1:0]     limit_q, limit_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic [15:0]       stuff_count_q, stuff_count_d;

    logic              adv;
    logic              do_next;
    logic [IW-1:0]     nxt_idx;
    logic [7:0]        nxt_byte;
    logic              has_next;
    logic [IW-1:0]     lim_in;

    function automatic logic [7:0] byte_at(input logic [WORD_W-1:0] w, input logic [IW-1:0] i);
        logic [WORD_W-1:0] s;
        s = w << (8 * i);
        return s[WORD_W-1 -: 8];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Byte count of a word; zero or out-of-range counts mean a full word
    function automatic logic [IW-1:0] word_limit(input logic eop, input logic [BW-1:0] nbytes);
        if (!eop || nbytes == '0 || int'(nbytes) > NB)
            return IW'(NB);
        return {1'b0, nbytes};
    endfunction

    assign adv      = out_valid_q & out_ready;
    assign nxt_idx  = idx_q + 1'b1;
    assign nxt_byte = byte_at(word_q, nxt_idx);
    assign has_next = (nxt_idx < limit_q);
    assign lim_in   = word_limit(in_eop, in_bytes);

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        eop_d         = eop_q;
        limit_d       = limit_q;
        idx_d         = idx_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        stuff_count_d = stuff_count_q;
        do_next       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    word_d      = in_data;
                    eop_d       = in_eop;
                    limit_d     = lim_in;
                    idx_d       = '0;
                    state_d     = S_DATA;
                    out_valid_d = 1'b1;
                    out_data_d  = in_data[WORD_W-1 -: 8];
                    out_sop_d   = in_sop;
                    out_eop_d   = !EMIT_EOI && in_eop && (lim_in == IW'(1)) &&
                                  (in_data[WORD_W-1 -: 8] != 8'hFF);
                    if (in_sop)
                        stuff_count_d = '0;
                end
            end
            S_DATA: begin
                if (adv) begin
                    out_sop_d = 1'b0;
                    if (out_data_q == 8'hFF) begin
                        state_d       = S_STUFF;
                        out_data_d    = 8'h00;
                        stuff_count_d = sat_inc(stuff_count_q);
                        out_eop_d     = !EMIT_EOI && eop_q && !has_next;
                    end else begin
                        do_next = 1'b1;
                    end
                end
            end
            S_STUFF: begin
                if (adv) begin
                    out_sop_d = 1'b0;
                    do_next   = 1'b1;
                end
            end
            S_EOI_FF: begin
                if (adv) begin
                    state_d    = S_EOI_D9;
                    out_data_d = 8'hD9;
                    out_sop_d  = 1'b0;
                    out_eop_d  = 1'b1;
                end
            end
            S_EOI_D9: begin
                if (adv) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_eop_d   = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Shared "next data byte / EOI / done" step after a non-0xFF byte or a stuff byte
        if (do_next) begin
            if (has_next) begin
                state_d    = S_DATA;
                idx_d      = nxt_idx;
                out_data_d = nxt_byte;
                out_eop_d  = !EMIT_EOI && eop_q && (nxt_idx + 1'b1 >= limit_q) &&
                             (nxt_byte != 8'hFF);
            end else if (eop_q && EMIT_EOI) begin
                state_d    = S_EOI_FF;
                out_data_d = 8'hFF;
                out_eop_d  = 1'b0;
            end else begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_eop_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            word_q        <= '0;
            eop_q         <= 1'b0;
            limit_q       <= '0;
            idx_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'h00;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            stuff_count_q <= '0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            eop_q         <= eop_d;
            limit_q       <= limit_d;
            idx_q         <= idx_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            stuff_count_q <= stuff_count_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign stuff_count = stuff_count_q;

endmodule
